// File: rtl/outel_irq_pkg.sv
// Shared register offsets, vector type and HIGHEST priority encoder for the
// outel8227 interrupt controller.
package outel_irq_pkg;

  localparam logic [2:0] OFF_STATUS  = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_MODE    = 3'd2;
  localparam logic [2:0] OFF_POLAR   = 3'd3;
  localparam logic [2:0] OFF_HIGHEST = 3'd4;

  typedef logic [7:0] irq_vec_t;

  localparam irq_vec_t NO_IRQ = 8'hFF;

  // Index of the highest-numbered set bit, NO_IRQ when the vector is empty.
  function automatic irq_vec_t highest_idx(input irq_vec_t vec);
    irq_vec_t idx;
    idx = NO_IRQ;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) begin
        idx = irq_vec_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/outel_sync_edge.sv
// Multi-flop input synchronizer with an edge detector whose sense is chosen by
// polar; history is kept on the raw synchronized level.
module outel_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  input  logic polar,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain and one-cycle history of the synchronized level.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];

  // Polarity only selects which transition counts, so flipping it cannot
  // manufacture an edge out of the stored history.
  always_comb begin
    rise = 1'b0;
    if (polar) begin
      rise = level & ~prev_r;
    end else begin
      rise = ~level & prev_r;
    end
  end

endmodule

// File: rtl/outel_irq_ctrl.sv
// Memory-mapped IRQ/NMI controller driving the outel8227 active-low nIRQ and
// nNMI pins from synchronized external sources.
module outel_irq_ctrl
  import outel_irq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hF000,
  parameter int          NUM_SRC     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int          NMI_PULSE   = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [15:0]        bus_addr,
  input  logic [7:0]         bus_wdata,
  input  logic               bus_rw,
  input  logic               bus_valid,
  output logic [7:0]         bus_rdata,
  output logic               bus_rd_sel,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               nmi_src,
  output logic               cpu_nirq,
  output logic               cpu_nnmi
);

  localparam irq_vec_t   SRC_MASK = irq_vec_t'((9'd1 << NUM_SRC) - 9'd1);
  localparam logic [7:0] NMI_LOAD = 8'(NMI_PULSE);

  irq_vec_t   status_r, enable_r, mode_r, polar_r;
  logic [7:0] nmi_cnt_r;
  logic [7:0] rdata_r;
  logic       rd_sel_r;

  irq_vec_t   lvl_s, edge_s, act_s, w1c_s, status_nxt_s, highest_s;
  logic [7:0] rd_val_s;
  logic [2:0] off_s;
  logic       hit_s, wr_s, rd_s;
  logic       nmi_lvl_s, nmi_edge_s, nmi_rise_s;

  for (genvar gi = 0; gi < 8; gi++) begin : g_src
    if (gi < NUM_SRC) begin : g_used
      outel_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .nrst  (nrst),
        .din   (irq_src[gi]),
        .polar (polar_r[gi]),
        .level (lvl_s[gi]),
        .rise  (edge_s[gi])
      );
    end else begin : g_unused
      assign lvl_s[gi]  = 1'b0;
      assign edge_s[gi] = 1'b0;
    end
  end

  outel_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk   (clk),
    .nrst  (nrst),
    .din   (nmi_src),
    .polar (1'b1),
    .level (nmi_lvl_s),
    .rise  (nmi_edge_s)
  );

  assign nmi_rise_s = nmi_edge_s & nmi_lvl_s;

  // Bus decode, pending-bit next state and read mux.
  always_comb begin
    hit_s    = (bus_addr[15:3] == BASE_ADDR[15:3]);
    wr_s     = bus_valid & ~bus_rw & hit_s;
    rd_s     = bus_valid & bus_rw & hit_s;
    off_s    = bus_addr[2:0];
    act_s    = (lvl_s ^ ~polar_r) & SRC_MASK;
    w1c_s    = 8'h00;
    rd_val_s = 8'h00;
    if (wr_s && (off_s == OFF_STATUS)) begin
      w1c_s = bus_wdata;
    end else begin
      w1c_s = 8'h00;
    end
    // Edge bits: clear-then-set so a coincident edge beats W1C; level bits track s.
    status_nxt_s = ((mode_r & ((status_r & ~w1c_s) | edge_s)) | (~mode_r & act_s)) & SRC_MASK;
    highest_s    = highest_idx(status_r & enable_r);
    case (off_s)
      OFF_STATUS:  rd_val_s = status_r;
      OFF_ENABLE:  rd_val_s = enable_r;
      OFF_MODE:    rd_val_s = mode_r;
      OFF_POLAR:   rd_val_s = polar_r;
      OFF_HIGHEST: rd_val_s = highest_s;
      default:     rd_val_s = 8'h00;
    endcase
  end

  // Control/status registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      status_r <= 8'h00;
      enable_r <= 8'h00;
      mode_r   <= 8'h00;
      polar_r  <= 8'h00;
    end else begin
      status_r <= status_nxt_s;
      if (wr_s) begin
        case (off_s)
          OFF_ENABLE: enable_r <= bus_wdata & SRC_MASK;
          OFF_MODE:   mode_r   <= bus_wdata & SRC_MASK;
          OFF_POLAR:  polar_r  <= bus_wdata & SRC_MASK;
          default:    enable_r <= enable_r;
        endcase
      end else begin
        enable_r <= enable_r;
      end
    end
  end

  // NMI pulse counter; a new edge reloads it so the pulse stretches seamlessly.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      nmi_cnt_r <= 8'd0;
    end else if (nmi_rise_s) begin
      nmi_cnt_r <= NMI_LOAD;
    end else if (nmi_cnt_r != 8'd0) begin
      nmi_cnt_r <= nmi_cnt_r - 8'd1;
    end else begin
      nmi_cnt_r <= nmi_cnt_r;
    end
  end

  // Read data is presented for exactly one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_sel_r <= 1'b0;
      rdata_r  <= 8'h00;
    end else if (rd_s) begin
      rd_sel_r <= 1'b1;
      rdata_r  <= rd_val_s;
    end else begin
      rd_sel_r <= 1'b0;
      rdata_r  <= 8'h00;
    end
  end

  assign bus_rd_sel = rd_sel_r;
  assign bus_rdata  = rdata_r;
  assign cpu_nirq   = ~|(status_r & enable_r);
  assign cpu_nnmi   = (nmi_cnt_r == 8'd0);

endmodule

// File: tb/tb_outel_irq_ctrl.sv
// Directed self-checking bench for outel_irq_ctrl; inputs change and outputs
// are sampled on the falling clock edge.
module tb_outel_irq_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic        bus_valid;
  logic [7:0]  bus_rdata;
  logic        bus_rd_sel;
  logic [7:0]  irq_src;
  logic        nmi_src;
  logic        cpu_nirq;
  logic        cpu_nnmi;

  int checks = 0;
  int errors = 0;

  outel_irq_ctrl #(
    .BASE_ADDR   (16'hF000),
    .NUM_SRC     (8),
    .SYNC_STAGES (2),
    .NMI_PULSE   (4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rw     (bus_rw),
    .bus_valid  (bus_valid),
    .bus_rdata  (bus_rdata),
    .bus_rd_sel (bus_rd_sel),
    .irq_src    (irq_src),
    .nmi_src    (nmi_src),
    .cpu_nirq   (cpu_nirq),
    .cpu_nnmi   (cpu_nnmi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    bus_valid = 1'b1;
    bus_rw    = 1'b0;
    bus_addr  = a;
    bus_wdata = d;
    @(negedge clk);
    bus_valid = 1'b0;
    bus_rw    = 1'b1;
  endtask

  task automatic bus_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus_valid = 1'b1;
    bus_rw    = 1'b1;
    bus_addr  = a;
    @(negedge clk);
    bus_valid = 1'b0;
    check_eq({tag, "_sel"}, 32'(bus_rd_sel), 32'd1);
    check_eq(tag, 32'(bus_rdata), 32'(exp));
    @(negedge clk);
    check_eq({tag, "_drop"}, {23'd0, bus_rd_sel, bus_rdata}, 32'd0);
  endtask

  // Drives nmi_src from pat one bit per cycle and measures the nNMI low pulse.
  task automatic nmi_run(input string tag, input logic [19:0] pat, input int exp_len);
    int   lows  = 0;
    int   falls = 0;
    logic prev  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nmi_src = pat[i];
      @(negedge clk);
      if (!cpu_nnmi) lows++;
      if (prev && !cpu_nnmi) falls++;
      prev = cpu_nnmi;
    end
    check_eq({tag, "_len"}, 32'(lows), 32'(exp_len));
    check_eq({tag, "_falls"}, 32'(falls), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nrst      = 1'b0;
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    bus_rw    = 1'b1;
    bus_valid = 1'b0;
    irq_src   = 8'hFE;
    nmi_src   = 1'b0;
    wait_cyc(3);
    check_eq("rst_nirq", 32'(cpu_nirq), 32'd1);
    check_eq("rst_nnmi", 32'(cpu_nnmi), 32'd1);
    check_eq("rst_rd_sel", 32'(bus_rd_sel), 32'd0);
    check_eq("rst_rdata", 32'(bus_rdata), 32'd0);
    nrst = 1'b1;
    wait_cyc(4);

    // 1: edge-triggered rising source on bit 0
    bus_wr(16'hF003, 8'h01);
    bus_wr(16'hF002, 8'h01);
    bus_wr(16'hF001, 8'h01);
    check_eq("t1_idle_nirq", 32'(cpu_nirq), 32'd1);
    bus_rd("t1_status0", 16'hF000, 8'h00);
    irq_src[0] = 1'b1;
    wait_cyc(2);
    check_eq("t1_lat2_nirq", 32'(cpu_nirq), 32'd1);
    wait_cyc(1);
    check_eq("t1_lat3_nirq", 32'(cpu_nirq), 32'd0);
    bus_rd("t1_status", 16'hF000, 8'h01);
    bus_rd("t1_highest", 16'hF004, 8'h00);
    bus_wr(16'hF000, 8'h01);
    check_eq("t1_w1c_nirq", 32'(cpu_nirq), 32'd1);

    // 2: level-mode, active-low bit 3
    bus_wr(16'hF001, 8'h08);
    irq_src[3] = 1'b0;
    wait_cyc(3);
    check_eq("t2_level_nirq", 32'(cpu_nirq), 32'd0);
    bus_wr(16'hF000, 8'h08);
    bus_rd("t2_w1c_held", 16'hF000, 8'h08);
    irq_src[3] = 1'b1;
    wait_cyc(2);
    check_eq("t2_rel2_nirq", 32'(cpu_nirq), 32'd0);
    wait_cyc(1);
    check_eq("t2_rel3_nirq", 32'(cpu_nirq), 32'd1);

    // 3: mode/polarity change makes no edge; edge beats coincident W1C
    bus_wr(16'hF002, 8'h21);
    bus_wr(16'hF003, 8'h21);
    wait_cyc(3);
    bus_rd("t3_no_fake", 16'hF000, 8'h00);
    irq_src[5] = 1'b0;
    wait_cyc(3);
    irq_src[5] = 1'b1;
    wait_cyc(2);
    bus_wr(16'hF000, 8'h20);
    bus_rd("t3_set_wins", 16'hF000, 8'h20);

    // 4: HIGHEST and masking
    irq_src[2] = 1'b0;
    irq_src[6] = 1'b0;
    wait_cyc(4);
    bus_rd("t4_status", 16'hF000, 8'h64);
    bus_wr(16'hF001, 8'h44);
    bus_rd("t4_hi_44", 16'hF004, 8'h06);
    check_eq("t4_nirq_44", 32'(cpu_nirq), 32'd0);
    bus_wr(16'hF001, 8'h04);
    bus_rd("t4_hi_04", 16'hF004, 8'h02);
    bus_wr(16'hF001, 8'h00);
    bus_rd("t4_hi_00", 16'hF004, 8'hFF);
    check_eq("t4_nirq_00", 32'(cpu_nirq), 32'd1);

    // 5: NMI pulse, extension, reset abort
    nmi_run("t5_single", 20'hFFFFF, 4);
    nmi_src = 1'b0;
    wait_cyc(4);
    check_eq("t5_idle_nnmi", 32'(cpu_nnmi), 32'd1);
    nmi_run("t5_extend", 20'hFFFFD, 6);
    nmi_src = 1'b0;
    wait_cyc(4);
    nmi_src = 1'b1;
    wait_cyc(4);
    check_eq("t5_mid_nnmi", 32'(cpu_nnmi), 32'd0);
    nrst    = 1'b0;
    nmi_src = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_abort_nnmi", 32'(cpu_nnmi), 32'd1);
    check_eq("t5_rst_nirq", 32'(cpu_nirq), 32'd1);
    nrst = 1'b1;
    wait_cyc(3);
    bus_rd("t5_rst_enable", 16'hF001, 8'h00);

    // 6: decode window
    bus_wr(16'hF001, 8'h5A);
    bus_rd("t6_enable", 16'hF001, 8'h5A);
    bus_wr(16'hF005, 8'hFF);
    bus_rd("t6_off5", 16'hF005, 8'h00);
    bus_valid = 1'b1;
    bus_rw    = 1'b1;
    bus_addr  = 16'hE001;
    @(negedge clk);
    bus_valid = 1'b0;
    check_eq("t6_miss_sel", 32'(bus_rd_sel), 32'd0);
    check_eq("t6_miss_rdata", 32'(bus_rdata), 32'd0);
    bus_wr(16'hE001, 8'hFF);
    bus_rd("t6_after_miss", 16'hF001, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
